// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: drives a synchronous ROM and buffers (address, instruction) pairs in a prefetch FIFO.
// Optional macro FETCH_BYPASS_EN presents a response arriving at an empty FIFO on the outputs in the same cycle.
module if_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     PC_IFWrite,
  input  logic                     Redirect,
  input  logic [31:0]              RedirectAddr,
  output logic                     ImemReq,
  output logic [31:0]              ImemAddr,
  input  logic [31:0]              ImemData,
  output logic                     Valid_if,
  output logic [31:0]              PC,
  output logic [31:0]              NextPC_if,
  output logic [31:0]              Instruction_if,
  output logic [$clog2(DEPTH):0]   Count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = DEPTH[CW:0];

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          inflight_q, inflight_d;
  logic [31:0]   resp_addr_q;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [31:0]   data_mem [DEPTH];
  logic [31:0]   addr_mem [DEPTH];

  logic          fifo_empty, push, pop, wr_en, rd_en, bypass_take;
  logic [CW:0]   occ_after;
  logic [31:0]   head_pc, head_instr;

  assign fifo_empty = (count_q == '0);
  // A response issued in the cycle before a redirect belongs to the old stream and is dropped.
  assign push       = inflight_q & ~Redirect;

`ifdef FETCH_BYPASS_EN
  assign Valid_if    = ~fifo_empty | push;
  assign head_pc     = fifo_empty ? resp_addr_q : addr_mem[head_q];
  assign head_instr  = fifo_empty ? ImemData    : data_mem[head_q];
  assign bypass_take = fifo_empty & pop;
`else
  assign Valid_if    = ~fifo_empty;
  assign head_pc     = addr_mem[head_q];
  assign head_instr  = data_mem[head_q];
  assign bypass_take = 1'b0;
`endif

  assign pop   = Valid_if & PC_IFWrite;
  assign wr_en = push & ~bypass_take;
  assign rd_en = pop & ~bypass_take;

  // Occupancy after this cycle's push/pop must leave room for the response a new request creates.
  assign occ_after = {1'b0, count_q} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};
  assign ImemReq   = ~reset & ~Redirect & (occ_after < DEPTH_W);
  assign ImemAddr  = fetch_pc_q;

  assign PC             = Valid_if ? head_pc : fetch_pc_q;
  assign NextPC_if      = PC + 32'd4;
  assign Instruction_if = Valid_if ? head_instr : 32'h0;
  assign Count          = count_q;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path infers a latch.
    fetch_pc_d = fetch_pc_q;
    inflight_d = 1'b0;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    if (Redirect) begin
      fetch_pc_d = {RedirectAddr[31:2], 2'b00};
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end else begin
      if (ImemReq) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        inflight_d = 1'b1;
      end
      if (wr_en) tail_d = tail_q + {{(PW-1){1'b0}}, 1'b1};
      if (rd_en) head_d = head_q + {{(PW-1){1'b0}}, 1'b1};
      count_d = count_q + {{PW{1'b0}}, wr_en} - {{PW{1'b0}}, rd_en};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q  <= RESET_PC;
      inflight_q  <= 1'b0;
      resp_addr_q <= RESET_PC;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      inflight_q  <= inflight_d;
      resp_addr_q <= fetch_pc_q;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
    end
  end

  // NOTE: FIFO storage is not reset; Count and the pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_mem[tail_q] <= ImemData;
      addr_mem[tail_q] <= resp_addr_q;
    end
  end

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Instruction-fetch front end that sits directly upstream of the IF->ID pipeline register.
- Drives a synchronous instruction ROM and buffers returned instructions, with their addresses, in a small prefetch FIFO.
- Presents the head entry to IF2ID and honours ID-stage stall (PC_IFWrite) and redirect (branch taken / J / JR).
- Hides ROM latency so a stalled ID stage does not throttle fetch.

Parameters:
DEPTH, 4, FIFO entries (power of two, >=2)
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
PC_IFWrite  input  1  consumer ready; head entry popped when Valid_if & PC_IFWrite
Redirect  input  1  flush request (Z|J|JR from ID)
RedirectAddr  input  32  new fetch address; bits [1:0] forced to 0
ImemReq  output  1  ROM read request this cycle
ImemAddr  output  32  ROM word address (byte address, [1:0]=0)
ImemData  input  32  ROM read data, valid the cycle after ImemReq
Valid_if  output  1  head entry valid
PC  output  32  head entry address when Valid_if, else current fetch PC
NextPC_if  output  32  PC + 4 (modulo 2^32)
Instruction_if  output  32  head instruction; 32'h0 (NOP) when !Valid_if
Count  output  clog2(DEPTH)+1  occupied FIFO entries

Behaviour:
- Reset (sync, high), all outputs at the next edge:
  - FetchPC=RESET_PC; Count=0; in-flight flag=0; head/tail pointers=0.
  - Valid_if=0; Instruction_if=0; PC=RESET_PC; NextPC_if=RESET_PC+4; ImemReq=0.
  - Reset asserted mid-operation discards FIFO contents and any in-flight response.
- Issue rule:
  - ImemReq=1 when !Redirect and Count + inflight - pop < DEPTH. No overrun, even with back-to-back requests.
  - ImemAddr=FetchPC. On issue: FetchPC<=FetchPC+4 and inflight<=1; otherwise inflight<=0.
- Response:
  - In the cycle after an issue (inflight=1), ImemData plus its address (registered copy of ImemAddr) are pushed at the tail.
- Pop:
  - Valid_if & PC_IFWrite advances head.
  - Push and pop in the same cycle leave Count unchanged; legal when full, because the issue rule guarantees room.
- Count:
  - Equals pushes minus pops, saturating never required.
  - Valid_if = (Count != 0).
- Steady state:
  - One instruction per cycle after the fill latency.
  - Fill latency from reset release: first ImemReq in cycle 1; Valid_if in cycle 3.
- Redirect (highest priority over push/pop/issue) in cycle T:
  - At the T edge: FIFO cleared (Count=0), inflight response from T-1 discarded, FetchPC<=RedirectAddr&~3. No ImemReq in T.
  - T+1: ImemReq=1, ImemAddr=target.
  - T+2: push.
  - T+3: Valid_if=1 with PC=target.
  - Redirect held for several cycles: each cycle re-applies the flush; the last cycle's target wins.
- PC_IFWrite=0 with Valid_if=1: head and outputs held stable. Fetch continues until full.
- PC_IFWrite ignored while !Valid_if.
- Address arithmetic wraps: FetchPC 32'hFFFF_FFFC + 4 = 0.
- Pointer wrap: head/tail are clog2(DEPTH)-bit and wrap naturally.

Optional Feature:
FETCH_BYPASS_EN
- Defined:
  - When Count==0 and a non-discarded response arrives, it is presented combinationally on Instruction_if/PC with Valid_if=1 in the same cycle.
  - If popped in that cycle it is not written to the FIFO; otherwise it is written.
  - Redirect penalty drops to 2 cycles (Valid_if at T+2); reset fill latency is 2.
- Undefined:
  - All responses go through the FIFO; latencies are as in Behaviour.

Test Plan:
1. Reset, then PC_IFWrite=1 constant, ROM word n = n -> Valid_if from cycle 3; PC 0,4,8,... one per cycle; Instruction_if 0,1,2,...; NextPC_if=PC+4.
2. PC_IFWrite=0 after first valid -> Count rises to 4 and ImemReq drops. Release -> PC sequence continues with no gap or duplicate, no instruction lost.
3. Redirect=1, RedirectAddr=32'h0000_0042 for one cycle while full -> Count=0 next cycle. ImemAddr=32'h40 at T+1. Valid_if with PC=32'h40 at T+3. Pre-redirect entries never appear.
4. Redirect in the cycle right after an issue -> the stale response is dropped; the first valid PC is the target.
5. Reset asserted for one cycle with FIFO half full and request in flight -> all outputs at reset values next cycle. Refetch starts at RESET_PC.
6. FetchPC=32'hFFFF_FFFC via redirect -> PC FFFF_FFFC, then 0; NextPC_if of first = 0. With FETCH_BYPASS_EN, Valid_if appears at T+2.
